// File: rtl/ram_rd_pkg.sv
// Shared constants and state type for the RAM read-side initiator.
package ram_rd_pkg;

  localparam int unsigned MEM_OFFSET = 206800;
  localparam int unsigned MEM_DEPTH  = 204900;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is read straight from the register array.
module stream_fifo #(
  parameter int unsigned DW    = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/ram_block_reader.sv
// Read-side RAM initiator: range-checks a request, walks the RAM port and streams words with a last flag.
module ram_block_reader
  import ram_rd_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_enw,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   base_ext;
  logic [WIDTH:0]   end_ext;
  logic             in_window;

  logic             f_full;
  logic             f_empty;
  logic [WIDTH:0]   f_dout;
  logic             push;
  logic             pop;
  logic             is_last;

  assign base_ext  = {1'b0, base_addr};
  assign end_ext   = base_ext + (WIDTH+1)'(word_count);
  assign in_window = (base_ext >= (WIDTH+1)'(MEM_OFFSET)) &&
                     (end_ext  <= (WIDTH+1)'(MEM_OFFSET + MEM_DEPTH));

  assign is_last = (rem_q == CNT_W'(1));
  assign pop     = ~f_empty & m_ready;
  assign push    = (state_q == READ) & (~f_full | pop);

  stream_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .din   ({is_last, mem_rdata}),
    .full  (f_full),
    .pop   (pop),
    .dout  (f_dout),
    .empty (f_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!in_window) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            if (word_count == '0) begin
              done_d = 1'b1;
            end else begin
              addr_d  = base_addr;
              rem_d   = word_count;
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (push) begin
          rem_d = rem_q - CNT_W'(1);
          // Address parks on the final word so the port never shows an out-of-window value.
          if (is_last) state_d = DRAIN;
          else         addr_d  = addr_q + WIDTH'(1);
        end
      end
      DRAIN: begin
        if (pop && f_dout[WIDTH]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      addr_q  <= WIDTH'(MEM_OFFSET);
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign mem_address = addr_q;
  assign mem_wdata   = '0;
  assign mem_enw     = 1'b0;
  assign m_valid     = ~f_empty;
  assign m_data      = f_dout[WIDTH-1:0];
  assign m_last      = ~f_empty & f_dout[WIDTH];

endmodule

// File: tb/tb_ram_block_reader.sv
// Scoreboard bench for ram_block_reader: driver queues expected words, monitor checks every transfer.
module tb_ram_block_reader;
  import ram_rd_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned FD    = 4;
  localparam longint      LO    = MEM_OFFSET;
  localparam longint      HI    = MEM_OFFSET + MEM_DEPTH;

  logic             clk;
  logic             nrst;
  logic             start;
  logic [WIDTH-1:0] base_addr;
  logic [CNT_W-1:0] word_count;
  logic             busy, done, err;
  logic [WIDTH-1:0] mem_address, mem_wdata, mem_rdata;
  logic             mem_enw;
  logic             m_valid, m_last, m_ready;
  logic [WIDTH-1:0] m_data;

  ram_block_reader #(
    .WIDTH      (WIDTH),
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_enw     (mem_enw),
    .mem_rdata   (mem_rdata),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents as a pure function of address.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  assign mem_rdata = ram_word(mem_address);

  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned accepted = 0;
  logic [31:0] cur_base = 0;
  int          ready_mode = 0;
  int unsigned rcnt = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (rcnt % 3 == 0);
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
    rcnt++;
  end

  // Monitor: handshake checks, scoreboard pops, backpressure address bound.
  always @(negedge clk) begin
    if (nrst) begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_word", {m_last, m_data}, prev_word);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none @%0t", m_data, $time);
        end else begin
          e = sb.pop_front();
          check("data", m_data, e.data);
          check("last", m_last, e.last);
        end
        accepted++;
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
      if (busy) check("addr_ahead", (mem_address - cur_base) <= accepted + FD, 1);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic issue(input logic [31:0] base, input int unsigned cnt);
    longint b, en;
    b  = base;
    en = b + cnt;
    cur_base = base;
    accepted = 0;
    if (b >= LO && en <= HI)
      for (int unsigned i = 0; i < cnt; i++) sb.push_back('{ram_word(base + i), i == cnt - 1});
    base_addr  = base;
    word_count = CNT_W'(cnt);
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_ok(input logic [31:0] base, input int unsigned cnt,
                        output int cyc, output int first, output logic busy1);
    issue(base, cnt);
    cyc   = 0;
    first = 0;
    busy1 = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = busy;
      if (m_valid && first == 0) first = cyc;
      if (done) break;
      if (cyc > 3000) begin
        check("done_timeout", 0, 1);
        break;
      end
    end
    check("busy_at_done", busy, 0);
    check("err_at_done", err, 0);
    check("sb_empty", sb.size(), 0);
    check("word_total", accepted, cnt);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_bad(input logic [31:0] base, input int unsigned cnt);
    logic [31:0] a0;
    a0 = mem_address;
    issue(base, cnt);
    repeat (4) begin
      @(negedge clk);
      check("bad_err", err, 1);
      check("bad_busy", busy, 0);
      check("bad_done", done, 0);
      check("bad_valid", m_valid, 0);
      check("bad_addr", mem_address, a0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, first;
    logic        b1;
    int unsigned cnt;
    longint      b;

    nrst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_addr", mem_address, MEM_OFFSET);
    check("rst_enw", mem_enw, 0);
    check("rst_wdata", mem_wdata, 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Full-throughput request: latency and done timing.
    ready_mode = 0;
    run_ok(32'd206800, 8, cyc, first, b1);
    check("t1_busy_c1", b1, 1);
    check("t1_first_valid", first, 2);
    check("t1_done_cycle", cyc, 10);

    // Backpressure pattern.
    ready_mode = 1;
    run_ok(32'd206900, 6, cyc, first, b1);

    // Below-window base, then a good request clears err.
    ready_mode = 0;
    run_bad(32'd206799, 1);
    run_ok(32'd206800, 2, cyc, first, b1);

    // Top-of-window boundary.
    run_ok(32'd411696, 4, cyc, first, b1);
    check("top_final_addr", mem_address, 32'd411699);
    run_bad(32'd411696, 5);

    // Zero-count request.
    run_ok(32'd300000, 0, cyc, first, b1);
    check("zero_done_cycle", cyc, 1);
    check("zero_no_valid", first, 0);

    // Reset mid-transfer.
    ready_mode = 0;
    issue(32'd207000, 10);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (accepted >= 3) break;
    end
    #3 nrst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_addr", mem_address, MEM_OFFSET);
    sb.delete();
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    run_ok(32'd250000, 5, cyc, first, b1);
    check("post_rst_first", first, 2);

    // Randomized requests, good and bad.
    for (int it = 0; it < 16; it++) begin
      ready_mode = $urandom_range(0, 2);
      cnt        = $urandom_range(1, 24);
      case ($urandom_range(0, 3))
        0:       b = LO - 1 - $urandom_range(0, 50);
        1:       b = HI - cnt + 1 + $urandom_range(0, 3);
        2:       b = HI - cnt;
        default: b = LO + $urandom_range(0, MEM_DEPTH - cnt);
      endcase
      if (b >= LO && b + cnt <= HI) run_ok(32'(b), cnt, cyc, first, b1);
      else                          run_bad(32'(b), cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
